// File: rtl/pipelined_instruction_decoder.sv
// Registered decode stage for the 8-bit teaching CPU: fetch register, one-cycle decode,
// jump-shadow squashing, general stall and a counted multi-cycle WAIT instruction.
module pipelined_instruction_decoder #(
  parameter logic [7:0] WAIT_OPC    = 8'hDF,
  parameter int         WAIT_CYCLES = 4,
  parameter int         CNT_W       = 4
) (
  input  logic       clk,
  input  logic       sync_reset,
  input  logic [7:0] next_instr,
  input  logic       stall,
  input  logic       nz_flag,
  output logic [7:0] ir,
  output logic [3:0] ir_nibble,
  output logic [8:0] reg_en,
  output logic [7:0] from_ID,
  output logic [3:0] source_sel,
  output logic       i_sel,
  output logic       x_sel,
  output logic       y_sel,
  output logic       jmp,
  output logic       jmp_nz,
  output logic       branch_taken,
  output logic       nop,
  output logic       fetch_hold
);

  // state    | meaning
  // ST_RUN   | normal fetch/decode; a WAIT in ir starts the hold
  // ST_WAIT  | WAIT issued; ir frozen, decode emits bubbles until cnt reaches 0
  typedef enum logic {ST_RUN, ST_WAIT} state_t;

  typedef struct packed {
    logic [8:0] reg_en;
    logic [3:0] source_sel;
    logic [3:0] ir_nibble;
    logic       i_sel;
    logic       x_sel;
    logic       y_sel;
    logic       jmp;
    logic       jmp_nz;
    logic       nop;
  } dec_t;

  localparam dec_t RESET_OUT = '{reg_en: 9'h1FF, source_sel: 4'd10, ir_nibble: 4'd0,
                                 i_sel: 1'b0, x_sel: 1'b0, y_sel: 1'b0,
                                 jmp: 1'b0, jmp_nz: 1'b0, nop: 1'b0};
  localparam dec_t BUBBLE_OUT = '{reg_en: 9'h000, source_sel: 4'd0, ir_nibble: 4'd0,
                                  i_sel: 1'b0, x_sel: 1'b0, y_sel: 1'b0,
                                  jmp: 1'b0, jmp_nz: 1'b0, nop: 1'b1};
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  function automatic dec_t decode(input logic [7:0] instr);
    dec_t       d;
    logic [2:0] ddd;
    logic [2:0] sss;
    d           = '0;
    d.ir_nibble = instr[3:0];
    ddd         = instr[5:3];
    sss         = instr[2:0];
    if (instr == 8'hC8 || instr == 8'hCF || instr == 8'hD8 || instr == WAIT_OPC) begin
      d.nop = 1'b1;
    end else if (!instr[7]) begin
      d.reg_en[instr[6:4]] = 1'b1;
      if (instr[6:5] == 2'b11) d.reg_en[6] = 1'b1;
      d.source_sel = 4'd8;
      d.i_sel      = (instr[6:4] != 3'd6);
    end else if (!instr[6]) begin
      // move: destination 4 (r) is redirected to the output register
      if (ddd == 3'd4) d.reg_en[8] = 1'b1;
      else             d.reg_en[ddd] = 1'b1;
      if (ddd[2:1] == 2'b11 || sss == 3'd7) d.reg_en[6] = 1'b1;
      if (sss == 3'd4)      d.source_sel = 4'd4;
      else if (sss == ddd)  d.source_sel = 4'd9;
      else                  d.source_sel = {1'b0, sss};
      d.i_sel = (ddd != 3'd6);
    end else if (!instr[5]) begin
      d.reg_en[4]  = 1'b1;
      d.x_sel      = instr[4];
      d.y_sel      = instr[3];
      d.source_sel = {1'b0, sss};
      d.i_sel      = 1'b1;
    end else begin
      d.jmp        = !instr[4];
      d.jmp_nz     = instr[4];
      d.source_sel = {1'b0, sss};
      d.i_sel      = 1'b1;
    end
    return d;
  endfunction

  state_t           state;
  logic [CNT_W-1:0] cnt;
  dec_t             out_q;
  logic             wait_detect;

  assign branch_taken = out_q.jmp | (out_q.jmp_nz & nz_flag);
  assign wait_detect  = (state == ST_RUN) && (ir == WAIT_OPC) && !branch_taken;
  assign fetch_hold   = stall | wait_detect | ((state == ST_WAIT) && (cnt != '0));

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      ir    <= 8'hC8;
      state <= ST_RUN;
      cnt   <= '0;
      out_q <= RESET_OUT;
    end else if (!stall) begin
      if (branch_taken) begin
        out_q <= BUBBLE_OUT;
        ir    <= next_instr;
      end else if (state == ST_WAIT) begin
        out_q <= BUBBLE_OUT;
        if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end else begin
          ir    <= next_instr;
          state <= ST_RUN;
        end
      end else if (wait_detect) begin
        state <= ST_WAIT;
        cnt   <= WAIT_INIT;
        out_q <= decode(ir);
      end else begin
        out_q <= decode(ir);
        ir    <= next_instr;
      end
    end
  end

  assign reg_en     = out_q.reg_en;
  assign from_ID    = out_q.reg_en[7:0];
  assign source_sel = out_q.source_sel;
  assign ir_nibble  = out_q.ir_nibble;
  assign i_sel      = out_q.i_sel;
  assign x_sel      = out_q.x_sel;
  assign y_sel      = out_q.y_sel;
  assign jmp        = out_q.jmp;
  assign jmp_nz     = out_q.jmp_nz;
  assign nop        = out_q.nop;

endmodule
